instr_decoder_pipe: RTL and testbench

Parametrised, pipelined successor to the nanoprocessor instruction decoder. It accepts instructions from program memory over a valid/ready handshake and holds them in an IR stage. Decoded datapath controls are then registered into an execute (EX) stage. The block adds stall, flush-on-jump and a retired-instruction counter, and generalises immediate/jump-target width. It sits between program memory/PC logic and the register-file/ALU datapath.

---
 rtl/instr_decoder_pipe.sv | 182 ++++++++++++++++++
 tb/tb_instr_decoder_pipe.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/instr_decoder_pipe.sv
// Two-stage (IR -> EX) instruction decoder with valid/ready intake, stall, flush-on-jump
// and a retired-instruction counter. Decoded datapath controls are registered in EX.
module instr_decoder_pipe #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATA_W+3:0]   instr_in,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic                stall,
    input  logic                flush,
    output logic [DATA_W+3:0]   ir,
    output logic                out_valid,
    output logic                jmp,
    output logic                jmp_nz,
    output logic [DATA_W-1:0]   imm,
    output logic                i_sel,
    output logic                x_sel,
    output logic                y_sel,
    output logic [3:0]          source_sel,
    output logic [8:0]          reg_en,
    output logic [3:0]          nop,
    output logic [CNT_W-1:0]    instr_count
);

    localparam int IW = DATA_W + 4;

    logic [IW-1:0]     ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic              ex_valid_q, ex_valid_d;
    logic [8:0]        ex_reg_en_q, ex_reg_en_d;
    logic [3:0]        ex_src_q, ex_src_d;
    logic              ex_jmp_q, ex_jmp_d;
    logic              ex_jmp_nz_q, ex_jmp_nz_d;
    logic [3:0]        ex_nop_q, ex_nop_d;
    logic              ex_i_sel_q, ex_i_sel_d;
    logic              ex_x_sel_q, ex_x_sel_d;
    logic              ex_y_sel_q, ex_y_sel_d;
    logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [2:0]        ld_dst, mv_dst, mv_src;
    logic [7:0]        op_byte;
    logic [8:0]        dec_reg_en;
    logic [3:0]        dec_src;
    logic              dec_i_sel, dec_jmp, dec_jmp_nz;
    logic [3:0]        dec_nop;

    // Decode of the IR-stage word
    always_comb begin
        ld_dst     = ir_q[IW-2:IW-4];
        mv_dst     = ir_q[IW-3:IW-5];
        mv_src     = ir_q[IW-6:IW-8];
        op_byte    = ir_q[IW-1:IW-8];
        dec_reg_en = 9'h000;
        dec_src    = 4'd8;
        dec_i_sel  = 1'b1;
        dec_jmp    = 1'b0;
        dec_jmp_nz = 1'b0;
        dec_nop    = {op_byte == 8'hDF, op_byte == 8'hD8, op_byte == 8'hCF, op_byte == 8'hC8};
        if (!ir_q[IW-1]) begin
            if (ld_dst == 3'd7)      dec_reg_en = 9'h0C0;
            else if (ld_dst == 3'd4) dec_reg_en = 9'h100;
            else                     dec_reg_en = 9'h001 << ld_dst;
            if (ld_dst == 3'd6)      dec_i_sel = 1'b0;
        end else if (!ir_q[IW-2]) begin
            if (mv_dst == 3'd4 && mv_src == 3'd4)
                dec_reg_en = 9'h100;
            else if (mv_dst == 3'd7 || (mv_src == 3'd7 && mv_dst != 3'd6))
                dec_reg_en = (9'h001 << mv_dst) | 9'h040;
            else if (mv_dst == 3'd4)
                dec_reg_en = 9'h100;
            else
                dec_reg_en = 9'h001 << mv_dst;
            if (mv_src == mv_dst) dec_src = (mv_src == 3'd4) ? 4'd4 : 4'd9;
            else                  dec_src = {1'b0, mv_src};
            if (mv_dst == 3'd6)   dec_i_sel = 1'b0;
        end else if (!ir_q[IW-3]) begin
            dec_reg_en = 9'h010;
        end else if (!ir_q[IW-4]) begin
            dec_jmp = 1'b1;
        end else begin
            dec_jmp_nz = 1'b1;
        end
    end

    // Pipeline advance: flush beats stall; stall freezes everything
    always_comb begin
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        ex_valid_d  = ex_valid_q;
        ex_reg_en_d = ex_reg_en_q;
        ex_src_d    = ex_src_q;
        ex_jmp_d    = ex_jmp_q;
        ex_jmp_nz_d = ex_jmp_nz_q;
        ex_nop_d    = ex_nop_q;
        ex_i_sel_d  = ex_i_sel_q;
        ex_x_sel_d  = ex_x_sel_q;
        ex_y_sel_d  = ex_y_sel_q;
        ex_imm_d    = ex_imm_q;
        cnt_d       = cnt_q;
        if (flush || (!stall && !ir_valid_q)) begin
            ex_valid_d  = 1'b0;
            ex_reg_en_d = 9'h000;
            ex_src_d    = 4'd8;
            ex_jmp_d    = 1'b0;
            ex_jmp_nz_d = 1'b0;
            ex_nop_d    = 4'h0;
            ex_i_sel_d  = 1'b1;
            ex_x_sel_d  = 1'b0;
            ex_y_sel_d  = 1'b0;
        end else if (!stall) begin
            ex_valid_d  = 1'b1;
            ex_reg_en_d = dec_reg_en;
            ex_src_d    = dec_src;
            ex_jmp_d    = dec_jmp;
            ex_jmp_nz_d = dec_jmp_nz;
            ex_nop_d    = dec_nop;
            ex_i_sel_d  = dec_i_sel;
            ex_x_sel_d  = ir_q[IW-4];
            ex_y_sel_d  = ir_q[IW-5];
            ex_imm_d    = ir_q[DATA_W-1:0];
            cnt_d       = cnt_q + CNT_W'(1);
        end
        if (flush) begin
            ir_valid_d = 1'b0;
        end else if (!stall) begin
            ir_valid_d = instr_valid;
            if (instr_valid) ir_d = instr_in;
        end
    end

    // Reset drives a datapath-clearing pattern for the first edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            ex_valid_q  <= 1'b0;
            ex_reg_en_q <= 9'h1FF;
            ex_src_q    <= 4'd10;
            ex_jmp_q    <= 1'b0;
            ex_jmp_nz_q <= 1'b0;
            ex_nop_q    <= 4'h0;
            ex_i_sel_q  <= 1'b0;
            ex_x_sel_q  <= 1'b0;
            ex_y_sel_q  <= 1'b0;
            ex_imm_q    <= '0;
            cnt_q       <= '0;
        end else begin
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            ex_valid_q  <= ex_valid_d;
            ex_reg_en_q <= ex_reg_en_d;
            ex_src_q    <= ex_src_d;
            ex_jmp_q    <= ex_jmp_d;
            ex_jmp_nz_q <= ex_jmp_nz_d;
            ex_nop_q    <= ex_nop_d;
            ex_i_sel_q  <= ex_i_sel_d;
            ex_x_sel_q  <= ex_x_sel_d;
            ex_y_sel_q  <= ex_y_sel_d;
            ex_imm_q    <= ex_imm_d;
            cnt_q       <= cnt_d;
        end
    end

    assign instr_ready = !stall;
    assign ir          = ir_q;
    assign out_valid   = ex_valid_q;
    assign reg_en      = stall ? 9'h000 : ex_reg_en_q;
    assign jmp         = ex_jmp_q & ~stall;
    assign jmp_nz      = ex_jmp_nz_q & ~stall;
    assign imm         = ex_imm_q;
    assign i_sel       = ex_i_sel_q;
    assign x_sel       = ex_x_sel_q;
    assign y_sel       = ex_y_sel_q;
    assign source_sel  = ex_src_q;
    assign nop         = ex_nop_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_decoder_pipe.sv
// Directed bench for instr_decoder_pipe (DATA_W=4, CNT_W=4 so the counter wrap is reachable).
module tb_instr_decoder_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] instr_in;
    logic       instr_valid, instr_ready, stall, flush;
    logic [7:0] ir;
    logic       out_valid, jmp, jmp_nz, i_sel, x_sel, y_sel;
    logic [3:0] imm, source_sel, nop, instr_count;
    logic [8:0] reg_en;

    int n_chk  = 0;
    int n_pass = 0;

    instr_decoder_pipe #(.DATA_W(4), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .stall(stall), .flush(flush), .ir(ir),
        .out_valid(out_valid), .jmp(jmp), .jmp_nz(jmp_nz), .imm(imm), .i_sel(i_sel),
        .x_sel(x_sel), .y_sel(y_sel), .source_sel(source_sel), .reg_en(reg_en),
        .nop(nop), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
            $display("check %-14s got %0h exp %0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; instr_in = 8'h00; instr_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        tick(); tick();
        chk("rst_reg_en", reg_en, 9'h1FF);
        chk("rst_src", source_sel, 4'hA);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_cnt", instr_count, 4'd0);
        reset_n = 1'b1;
        tick();
        chk("rel_reg_en", reg_en, 9'h000);
        chk("rel_src", source_sel, 4'd8);

        // LOAD 75: dst 7 -> bits 7,6
        instr_in = 8'h75; instr_valid = 1'b1;
        tick();
        chk("ld_ir", ir, 8'h75);
        instr_valid = 1'b0;
        tick();
        chk("ld_valid", out_valid, 1'b1);
        chk("ld_reg_en", reg_en, 9'h0C0);
        chk("ld_imm", imm, 4'd5);
        chk("ld_isel", i_sel, 1'b1);
        chk("ld_src", source_sel, 4'd8);
        chk("ld_cnt", instr_count, 4'd1);

        // MOVE stream
        instr_in = 8'hA4; instr_valid = 1'b1; tick();
        instr_in = 8'h9B; tick();
        chk("mvA4_src", source_sel, 4'd4);
        chk("mvA4_reg_en", reg_en, 9'h100);
        instr_in = 8'hB7; tick();
        chk("mv9B_src", source_sel, 4'd9);
        chk("mv9B_reg_en", reg_en, 9'h008);
        instr_valid = 1'b0; tick();
        chk("mvB7_src", source_sel, 4'd7);
        chk("mvB7_reg_en", reg_en, 9'h040);
        chk("mvB7_isel", i_sel, 1'b0);
        chk("mv_cnt", instr_count, 4'd4);

        // ALU C8 then DF
        instr_in = 8'hC8; instr_valid = 1'b1; tick();
        instr_in = 8'hDF; tick();
        chk("aluC8_reg_en", reg_en, 9'h010);
        chk("aluC8_nop", nop, 4'b0001);
        chk("aluC8_x", x_sel, 1'b0);
        chk("aluC8_y", y_sel, 1'b1);
        instr_valid = 1'b0; tick();
        chk("aluDF_nop", nop, 4'b1000);
        chk("aluDF_x", x_sel, 1'b1);
        chk("alu_cnt", instr_count, 4'd6);

        // JUMP with flush in the jmp cycle
        instr_in = 8'hE3; instr_valid = 1'b1; tick();
        instr_in = 8'h11; tick();
        chk("jmp_jmp", jmp, 1'b1);
        chk("jmp_imm", imm, 4'd3);
        chk("jmp_reg_en", reg_en, 9'h000);
        instr_in = 8'h22; flush = 1'b1; tick();
        flush = 1'b0; instr_valid = 1'b0;
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_reg_en", reg_en, 9'h000);
        chk("fl_jmp", jmp, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("fl_bubble", out_valid, 1'b0);
        end
        chk("fl_cnt", instr_count, 4'd7);

        // Stall with a valid instruction waiting
        instr_in = 8'hA4; instr_valid = 1'b1; tick();
        instr_in = 8'h9B; tick();
        instr_in = 8'h75; stall = 1'b1; #1;
        chk("st_ready", instr_ready, 1'b0);
        chk("st_mask", reg_en, 9'h000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_ir", ir, 8'h9B);
            chk("st_reg_en", reg_en, 9'h000);
            chk("st_cnt", instr_count, 4'd8);
            chk("st_src", source_sel, 4'd4);
        end
        stall = 1'b0; tick();
        chk("rl_reg_en", reg_en, 9'h008);
        chk("rl_ir", ir, 8'h75);
        chk("rl_cnt", instr_count, 4'd9);
        instr_valid = 1'b0; tick();
        chk("rl_next", reg_en, 9'h0C0);
        chk("rl_cnt2", instr_count, 4'd10);
        tick();
        chk("rl_bubble", out_valid, 1'b0);
        chk("rl_cnt3", instr_count, 4'd10);

        // Six more retirements wrap the 4-bit counter to 0
        instr_in = 8'hC8; instr_valid = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        instr_valid = 1'b0; tick();
        chk("wrap_cnt", instr_count, 4'd0);
        tick();
        chk("wrap_hold", instr_count, 4'd0);

        // Reset mid-stream drops in-flight work
        instr_in = 8'h75; instr_valid = 1'b1; tick(); tick();
        reset_n = 1'b0; #1;
        chk("mr_valid", out_valid, 1'b0);
        chk("mr_reg_en", reg_en, 9'h1FF);
        chk("mr_ir", ir, 8'h00);
        instr_valid = 1'b0; tick();
        reset_n = 1'b1; tick();
        chk("mr_bubble", out_valid, 1'b0);
        chk("mr_cnt", instr_count, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
